// File: rtl/slc3_mem_seq_pkg.sv
// Shared types and defaults for the SLC-3 memory-access sequencer.
//   mem_seq_state_t : sequencer state encoding (IDLE, ACCESS, DONE, PAUSE1, PAUSE2)
//   RD_WAIT_DEF     : default read wait (sync BRAM plus output register = 3 cycles)
//   WR_WAIT_DEF     : default write wait
//   max_int         : helper used to size the shared wait counter
package slc3_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    DONE   = 3'd2,
    PAUSE1 = 3'd3,
    PAUSE2 = 3'd4
  } mem_seq_state_t;

  localparam int RD_WAIT_DEF = 3;
  localparam int WR_WAIT_DEF = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/slc3_mem_seq_wait_timer.sv
// Wait-state timer for the memory sequencer.
//   clk, reset : system clock, synchronous active-high reset (count -> 0)
//   load       : restart the count at 0 (first ACCESS cycle follows)
//   enable     : advance the count by one
//   last       : terminal value (wait length minus one)
//   tc         : high while the count equals last
module slc3_wait_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] last,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == last);

endmodule

// File: rtl/slc3_mem_seq.sv
// Memory-access sequencer for the SLC-3 ISDU. One shared timed sequence
// replaces the per-state BRAM wait chains.
//   clk, reset   : system clock, synchronous active-high reset
//   req_i, we_i  : start an access (write when we_i=1); sampled in IDLE, or in
//                  DONE when no pause is pending
//   pause_i      : stop in the debug pause after this access (PAUSE_EN=1 only)
//   continue_i   : debug continue button level (press, then release)
//   busy_o       : high in every state except IDLE
//   done_o       : one-cycle pulse when an access completes
//   mem_mem_ena  : memory enable, mem_wr_ena : memory write enable
//   ld_mdr       : load MDR from memory output (reads only)
//   ld_led       : load LED register during the pause
//   acc_cnt_o    : completed-access count, wraps at 2^CNT_W
//   state_o      : current sequencer state, for debug
// Handshake: req_i is a level the ISDU holds until it sees the sequencer
// accept it; acceptance happens only on an edge where the sequencer is in IDLE
// or in a non-pausing DONE. Nothing is queued while busy.
module slc3_mem_seq
  import slc3_pkg::*;
#(
  parameter int RD_WAIT  = RD_WAIT_DEF,
  parameter int WR_WAIT  = WR_WAIT_DEF,
  parameter int PAUSE_EN = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_i,
  input  logic             we_i,
  input  logic             pause_i,
  input  logic             continue_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             mem_mem_ena,
  output logic             mem_wr_ena,
  output logic             ld_mdr,
  output logic             ld_led,
  output logic [CNT_W-1:0] acc_cnt_o,
  output logic [2:0]       state_o
);

  if (RD_WAIT < 1) begin : g_bad_rd
    $error("slc3_mem_seq: RD_WAIT must be >= 1");
  end
  if (WR_WAIT < 1) begin : g_bad_wr
    $error("slc3_mem_seq: WR_WAIT must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("slc3_mem_seq: CNT_W must be >= 1");
  end

  // Counter wide enough to hold the longest wait, so N-1 never truncates.
  localparam int WCNT_W = $clog2(max_int(RD_WAIT, WR_WAIT) + 1);
  localparam logic [WCNT_W-1:0] RD_LAST = WCNT_W'(RD_WAIT - 1);
  localparam logic [WCNT_W-1:0] WR_LAST = WCNT_W'(WR_WAIT - 1);
  localparam logic PAUSE_ALLOWED = (PAUSE_EN != 0);

  mem_seq_state_t state_q, state_d;
  logic           we_q, pause_q;
  logic           start;
  logic           tc;

  slc3_wait_timer #(.W(WCNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (start),
    .enable (state_q == ACCESS),
    .last   (we_q ? WR_LAST : RD_LAST),
    .tc     (tc)
  );

  // State register plus the access attributes latched at acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      pause_q   <= 1'b0;
      acc_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        we_q    <= we_i;
        pause_q <= pause_i & PAUSE_ALLOWED;
      end
      // Count on entry to DONE so the new value is visible with done_o.
      if (state_q == ACCESS && tc) begin
        acc_cnt_o <= acc_cnt_o + CNT_W'(1);
      end
    end
  end

  // Next state; start marks an accepted request (IDLE or back-to-back DONE).
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = ACCESS;
          start   = 1'b1;
        end
      end
      ACCESS: begin
        if (tc) state_d = DONE;
      end
      DONE: begin
        if (pause_q) begin
          state_d = PAUSE1;
        end else if (req_i) begin
          state_d = ACCESS;
          start   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      PAUSE1: begin
        if (continue_i) state_d = PAUSE2;
      end
      PAUSE2: begin
        if (!continue_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs.
  always_comb begin
    busy_o      = 1'b1;
    done_o      = 1'b0;
    mem_mem_ena = 1'b0;
    mem_wr_ena  = 1'b0;
    ld_mdr      = 1'b0;
    ld_led      = 1'b0;
    unique case (state_q)
      IDLE:   busy_o = 1'b0;
      ACCESS: begin
        mem_mem_ena = 1'b1;
        mem_wr_ena  = we_q;
        ld_mdr      = ~we_q;
      end
      DONE:   done_o = 1'b1;
      PAUSE1: ld_led = 1'b1;
      PAUSE2: ld_led = 1'b1;
      default: busy_o = 1'b0;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_slc3_mem_seq.sv
module tb_slc3_mem_seq;

  localparam int RD  = 3;
  localparam int WR  = 1;
  localparam logic [31:0] CNT_MASK = 32'h0000_FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT (defaults) ----------------
  logic        req_i = 0, we_i = 0, pause_i = 0, continue_i = 0;
  logic        busy_o, done_o, mem_mem_ena, mem_wr_ena, ld_mdr, ld_led;
  logic [15:0] acc_cnt_o;
  logic [2:0]  state_o;

  slc3_mem_seq #(.RD_WAIT(RD), .WR_WAIT(WR), .PAUSE_EN(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .pause_i(pause_i),
    .continue_i(continue_i), .busy_o(busy_o), .done_o(done_o),
    .mem_mem_ena(mem_mem_ena), .mem_wr_ena(mem_wr_ena), .ld_mdr(ld_mdr),
    .ld_led(ld_led), .acc_cnt_o(acc_cnt_o), .state_o(state_o)
  );

  // ---------------- second DUT: 2-bit counter, pause disabled ----------------
  logic       req2 = 0, we2 = 0, pause2 = 0, cont2 = 0;
  logic       busy2, done2, mem2, wr2, mdr2, led2;
  logic [1:0] cnt2;
  logic [2:0] state2;

  slc3_mem_seq #(.RD_WAIT(RD), .WR_WAIT(WR), .PAUSE_EN(0), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .req_i(req2), .we_i(we2), .pause_i(pause2),
    .continue_i(cont2), .busy_o(busy2), .done_o(done2),
    .mem_mem_ena(mem2), .mem_wr_ena(wr2), .ld_mdr(mdr2),
    .ld_led(led2), .acc_cnt_o(cnt2), .state_o(state2)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each accepted access is expanded into its expected per-cycle output
  // vectors (N access cycles then one done cycle) and queued; the pause is a
  // small phase variable driven by the continue button.
  typedef struct packed {
    logic busy, mem, wr, mdr, done, led, pz;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         cur = '0;
  int          pphase = 0;   // 0 none, 1 waiting for press, 2 waiting for release
  logic [31:0] exp_cnt = 0;

  task automatic model_edge();
    ev_t e;
    int  n;
    if (reset) begin
      exp_q.delete();
      pphase  = 0;
      cur     = '0;
      exp_cnt = 0;
      return;
    end
    if (pphase == 1) begin
      if (continue_i) pphase = 2;
    end else if (pphase == 2) begin
      if (!continue_i) pphase = 0;
    end else if (exp_q.size() == 0) begin
      if (cur.done && cur.pz) begin
        pphase = 1;
      end else if (req_i) begin
        n = we_i ? WR : RD;
        for (int i = 0; i < n; i++) begin
          e = '0; e.busy = 1; e.mem = 1; e.wr = we_i; e.mdr = ~we_i;
          exp_q.push_back(e);
        end
        e = '0; e.busy = 1; e.done = 1; e.pz = pause_i;
        exp_q.push_back(e);
      end
    end
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
    end else if (pphase != 0) begin
      cur = '0; cur.busy = 1; cur.led = 1;
    end else begin
      cur = '0;
    end
    if (cur.done) exp_cnt = (exp_cnt + 1) & CNT_MASK;
  endtask

  // One clock: model advances at the edge, outputs compared at the negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("busy_o",      busy_o,      cur.busy);
    chk("done_o",      done_o,      cur.done);
    chk("mem_mem_ena", mem_mem_ena, cur.mem);
    chk("mem_wr_ena",  mem_wr_ena,  cur.wr);
    chk("ld_mdr",      ld_mdr,      cur.mdr);
    chk("ld_led",      ld_led,      cur.led);
    chk("acc_cnt_o",   acc_cnt_o,   exp_cnt);
  endtask

  task automatic drive(input logic r, input logic w, input logic p, input logic c);
    req_i = r; we_i = w; pause_i = p; continue_i = c;
  endtask

  task automatic idle_steps(input int n);
    drive(0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic seen;

    // Reset state
    reset = 1'b1;
    step();
    step();
    chk("rst_cnt_zero", acc_cnt_o, 32'd0);
    reset = 1'b0;
    idle_steps(2);

    // Reset during the 2nd ACCESS cycle of a read: aborted, no done, count 0
    drive(1, 0, 0, 0); step();
    drive(0, 0, 0, 0); step();
    reset = 1'b1;      step();
    chk("t5_done", done_o, 1'b0);
    reset = 1'b0;
    idle_steps(4);

    // Single read: 3 access cycles, done on the 4th
    drive(1, 0, 0, 0); step();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step();
    chk("t1_cnt", acc_cnt_o, 32'd1);

    // Single write: 1 access cycle, done on the 2nd
    drive(1, 1, 0, 0); step();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step();
    chk("t2_cnt", acc_cnt_o, 32'd2);

    // Three back-to-back reads with req held high
    drive(1, 0, 0, 0);
    for (int i = 0; i < 11; i++) step();
    drive(0, 0, 0, 0);
    step();
    chk("t3_done_last", done_o, 1'b1);
    idle_steps(2);
    chk("t3_cnt", acc_cnt_o, 32'd5);

    // Pause: read with pause_i, hold in PAUSE1, press, release
    drive(1, 0, 1, 0); step();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 10; i++) step();
    chk("t4_led_held", ld_led, 1'b1);
    drive(0, 0, 0, 1); step(); step();
    drive(1, 0, 0, 0); step();   // release; request ignored while pausing
    drive(0, 0, 0, 0); step();
    chk("t4_busy_after", busy_o, 1'b0);

    // Continue held on entry to the pause
    drive(1, 1, 1, 1); step();
    drive(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step();
    drive(0, 0, 0, 0);
    idle_steps(3);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0);
      step();
    end
    drive(0, 0, 0, 1); step(); step();
    idle_steps(6);

    // Second instance: wrap at 2 bits, pause path disabled
    for (int k = 0; k < 5; k++) begin
      req2 = 1'b1; we2 = k[0]; pause2 = 1'b1;
      step();
      req2 = 1'b0; pause2 = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 8 && !seen; t++) begin
        chk("d2_ld_led", led2, 1'b0);
        if (done2) begin
          seen = 1'b1;
          chk("d2_cnt", cnt2, (k + 1) % 4);
        end else begin
          step();
        end
      end
      chk("d2_done_seen", seen, 1'b1);
      step();
      chk("d2_busy_idle", busy2, 1'b0);
      chk("d2_led_idle", led2, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
